// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer around the registered ALU.
// One op in flight: accept, wait out ALU latency, hold result.
module alu_issue_ctrl #(
  parameter int NUMBITS = 16,
  parameter int CNTBITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] in_a,
  input  logic [NUMBITS-1:0] in_b,
  input  logic [2:0]         in_opcode,
  output logic [NUMBITS-1:0] alu_a,
  output logic [NUMBITS-1:0] alu_b,
  output logic [2:0]         alu_opcode,
  input  logic [NUMBITS-1:0] alu_result,
  input  logic               alu_carryout,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] out_result,
  output logic [2:0]         out_flags,
  output logic [CNTBITS-1:0] carry_count,
  output logic [CNTBITS-1:0] ovf_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;
  logic   capture;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): in_ready  = 1'b1;
      (state == S_WAIT): capture   = 1'b1;
      (state == S_HOLD): out_valid = 1'b1;
      default: ;
    endcase
  end

  assign accept = in_ready & in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'b000;
    end else if (accept) begin
      alu_a      <= in_a;
      alu_b      <= in_b;
      alu_opcode <= in_opcode;
    end
  end

  // ALU result register was loaded on the ISSUE edge; take it now
  always_ff @(posedge clk) begin
    if (reset) begin
      out_result <= '0;
      out_flags  <= 3'b000;
    end else if (capture) begin
      out_result <= alu_result;
      out_flags  <= {alu_carryout, alu_overflow, alu_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      carry_count <= '0;
      ovf_count   <= '0;
    end else if (capture) begin
      if (alu_carryout && (carry_count != '1)) begin
        carry_count <= carry_count + 1'b1;
      end
      if (alu_overflow && (ovf_count != '1)) begin
        ovf_count <= ovf_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing stage that wraps the registered ALU (`myalu`). It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode inputs. It waits out the ALU's one-clock register latency, then captures the ALU result and flags into a held output with its own valid/ready handshake. It also keeps saturating event counters for carry-out and overflow.

## Interface
- `NUMBITS`, 16, operand/result width; must equal the connected ALU's `NUMBITS`
- `CNTBITS`, 8, width of each event counter

- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high; same net drives the ALU's `reset`
- `in_valid` in 1: request present
- `in_ready` out 1: block can accept a request
- `in_a` in NUMBITS: operand A
- `in_b` in NUMBITS: operand B
- `in_opcode` in 3: ALU opcode, passed through unmodified
- `alu_a` out NUMBITS: to ALU `A`
- `alu_b` out NUMBITS: to ALU `B`
- `alu_opcode` out 3: to ALU `opcode`
- `alu_result` in NUMBITS: from ALU `result`
- `alu_carryout` in 1: from ALU `carryout`
- `alu_overflow` in 1: from ALU `overflow`
- `alu_zero` in 1: from ALU `zero`
- `out_valid` out 1: captured result available
- `out_ready` in 1: consumer takes the result
- `out_result` out NUMBITS: captured result
- `out_flags` out 3: captured `{carryout, overflow, zero}`
- `carry_count` out CNTBITS: number of captured results with carry=1; saturating
- `ovf_count` out CNTBITS: number of captured results with overflow=1; saturating

## Operation
- The FSM has four states.
  - IDLE: `in_ready`=1. On `in_valid`: register `in_a/in_b/in_opcode` into `alu_a/alu_b/alu_opcode`, go to ISSUE.
  - ISSUE: unconditional, go to WAIT. The ALU samples the operands on this edge.
  - WAIT: unconditional, go to HOLD. On this edge, load `out_result` and `out_flags` from the ALU outputs, set `out_valid`=1, and update the counters.
  - HOLD: `out_valid`=1. On `out_ready`, clear `out_valid` and go to IDLE. Otherwise stay.
- `in_ready` is a combinational decode of state==IDLE only. No request is accepted in ISSUE, WAIT or HOLD.
- `alu_a/alu_b/alu_opcode` change only on an accept edge. They hold their values between accepts.
- `out_result` and `out_flags` change only on the WAIT edge. They remain stable through HOLD and IDLE.
- The block does not interpret flags. For example, zero is asserted by the ALU only for opcode 000, and it is passed through as-is.
- Counters: each increments by 1 on the WAIT edge when its captured flag is 1. At all-ones, the counter holds (saturates). Counters are cleared only by `reset`.

## Timing
- Reset sets all of the following:
  - state=IDLE, `out_valid`=0
  - `alu_a`=`alu_b`=0, `alu_opcode`=000
  - `out_result`=0, `out_flags`=000
  - both counters=0
  - `in_ready` is 1 from the first post-reset cycle
- Latency: accept on edge N, capture on edge N+2, `out_valid` high in the cycle after edge N+2.
- Minimum issue interval: 4 cycles, when `out_ready` is held high.
- Reset in any state aborts the operation. No partial result is presented and the counters are not updated.
- If `out_ready` is high outside HOLD, it is ignored.
- If `in_valid` drops before it is accepted, that is legal. Nothing is latched.
- `in_valid` and `out_ready` can both be high in HOLD. The block completes the output handshake only; the new request is accepted in the following IDLE cycle.

## Test plan
- **Unsigned add with carry:** reset, then opcode 000, A=FFFF, B=0001.
  - `out_result`=0000, `out_flags`=100 with zero=1 (so 101), `carry_count`=1.
  - `out_valid` rises 2 edges after accept.
- **Signed add overflow:** opcode 001, A=7FFF, B=0001.
  - `out_result`=8000, overflow flag=1, `ovf_count` increments by 1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises.
  - `out_result`/`out_flags` stay stable and `in_ready`=0 throughout.
  - Raise `out_ready`: `out_valid`=0 the next cycle, and `in_ready`=1.
- **Back-to-back:** keep `in_valid`=1 with ops (100, A=F0F0, B=FF00) then (111, A=8001).
  - Results are F000 and 4000.
  - Second accept occurs exactly 4 cycles after the first with `out_ready`=1.
- **Saturation:** with CNTBITS=2, run 5 overflowing signed adds.
  - `ovf_count` reads 1, 2, 3, 3, 3.
- **Reset mid-operation:** assert `reset` in WAIT.
  - No `out_valid` pulse, counters=0, `out_result`=0.
  - The next request completes normally.
